dbg_uart_loader: RTL and testbench
==================================

Name: dbg_uart_loader

Overview:
- Upstream feeder of the SoC debug memory port: turns a received UART byte stream into word writes on dbg_mem_op/dbg_wren/dbg_adr/dbg_do.
- Controls cpu_n_reset, so a host can halt the CPU, load program ROM/RAM, then start it.
- Sits between the UART receiver/transmitter and the soc debug inputs.
- Replaces bench-side forcing of those signals with a real on-chip loader.

Parameters:
- TIMEOUT_CYCLES, 100000: idle clocks between bytes of one frame before the frame is abandoned.
- WRITE_CYCLES, 4: clocks dbg_mem_op is held high per word write (minimum 1).
- ACK_BYTE, 8'h4B: response byte for an accepted command ('K').
- NAK_BYTE, 8'h45: response byte for a rejected command ('E').

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  response pending; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data when tx_valid and tx_ready are both high
- cpu_n_reset  out  1  CPU reset, active low
- dbg_mem_op  out  1  debug memory access strobe
- dbg_wren  out  4  byte write enables
- dbg_adr  out  32  debug word address
- dbg_do  out  32  debug write data
- dbg_busy  out  1  high in WRITE and RESP states

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high (reset).
- Reset values:
  - cpu_n_reset=0: CPU is held in reset out of reset.
  - dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0.
  - tx_valid=0, tx_data=0, dbg_busy=0.
  - State=IDLE; all counters 0.
- Commands (first byte of a frame, in IDLE):
  - 'H' (8'h48): set cpu_n_reset=0, then respond ACK.
  - 'G' (8'h47): set cpu_n_reset=1, then respond ACK.
  - 'W' (8'h57): followed by 4 address bytes, then 4 data bytes, both little-endian. Then a word write and a response.
  - Any other byte: respond NAK; no other effect.
- States: IDLE, ADDR, DATA, WRITE, RESP.
  - IDLE: on rx_valid, decode the command. 'W' -> ADDR with byte index 0. Other commands -> RESP with the response byte latched.
  - ADDR: each rx_valid shifts rx_data into address byte[idx]; idx increments. After the 4th byte -> DATA with idx=0.
  - DATA: same as ADDR, filling the data word. After the 4th byte:
    - If cpu_n_reset=1 (CPU running): -> RESP with NAK. No write occurs.
    - Otherwise -> WRITE.
  - WRITE: dbg_adr = {addr[31:2], 2'b00} (low two address bits ignored), dbg_do = data, dbg_wren = 4'hF, dbg_mem_op = 1. These hold for exactly WRITE_CYCLES clocks, starting the cycle after the last data byte. Then dbg_mem_op and dbg_wren return to 0 and the state goes to RESP with ACK. dbg_adr and dbg_do keep their last values.
  - RESP: tx_valid=1 with tx_data fixed. On the cycle tx_valid and tx_ready are both high, tx_valid drops next cycle and the state returns to IDLE.
- Response latency: tx_valid rises one clock after the final command byte ('H', 'G', NAK), or one clock after the last WRITE cycle.
- cpu_n_reset changes on the clock after the 'H' or 'G' byte is received.
- rx_valid during WRITE or RESP: the byte is dropped (no buffering). The host must wait for the response.
- Timeout: in ADDR or DATA, a counter increments each clock without rx_valid and clears on rx_valid. When it reaches TIMEOUT_CYCLES, return to IDLE silently: no write, no response, cpu_n_reset unchanged. The counter is inactive in the other states.
- A 'W' byte value inside the address or data payload is treated as payload, not as a command.
- reset asserted in any state, including mid-WRITE: the next clock gives the reset values. This de-asserts dbg_mem_op immediately and halts the CPU.

Test Plan:
- After reset -> cpu_n_reset=0, dbg_mem_op=0, tx_valid=0. Send 'W', 00 00 02 00, 6F 00 00 00 with tx_ready=1 -> dbg_adr=32'h20000, dbg_do=32'h0000006F, dbg_wren=4'hF, dbg_mem_op high for exactly 4 clocks, then tx_data=8'h4B for one cycle.
- Write frame with address bytes 07 00 02 00 and data 01 00 00 00 -> dbg_adr=32'h20004, dbg_do=32'h1, ACK.
- 'G' -> cpu_n_reset=1 and ACK. Then a full 'W' frame -> no dbg_mem_op pulse, NAK (8'h45). Then 'H' -> cpu_n_reset=0 and ACK.
- Byte 8'hAA in IDLE -> NAK, no state change. tx_ready held low 10 clocks -> tx_valid and tx_data stable throughout; an rx byte sent meanwhile is ignored.
- 'W' plus 3 address bytes, then TIMEOUT_CYCLES idle clocks (bench uses TIMEOUT_CYCLES=50) -> back in IDLE, no tx_valid, no write. A following complete frame writes correctly.
- Assert reset on the 2nd WRITE clock -> dbg_mem_op=0, dbg_wren=0, cpu_n_reset=0 on the next clock; no response is emitted.

Source files
------------

// File: rtl/dbg_uart_loader.sv
// UART-driven debug loader: decodes host byte frames into CPU halt/go control and
// debug-port word writes, answering every accepted or rejected command with one byte.
module dbg_uart_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned WRITE_CYCLES   = 4,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cpu_n_reset,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    output logic        dbg_busy
);

    localparam logic [7:0] CmdHalt  = 8'h48;
    localparam logic [7:0] CmdGo    = 8'h47;
    localparam logic [7:0] CmdWrite = 8'h57;

    typedef enum logic [2:0] {StIdle, StAddr, StData, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        cpu_n_reset_q, cpu_n_reset_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] do_q, do_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            addr_q        <= 32'd0;
            data_q        <= 32'd0;
            wcnt_q        <= 32'd0;
            tcnt_q        <= 32'd0;
            tx_data_q     <= 8'd0;
            cpu_n_reset_q <= 1'b0;
            adr_q         <= 32'd0;
            do_q          <= 32'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wcnt_q        <= wcnt_d;
            tcnt_q        <= tcnt_d;
            tx_data_q     <= tx_data_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            adr_q         <= adr_d;
            do_q          <= do_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wcnt_d        = wcnt_q;
        tcnt_d        = tcnt_q;
        tx_data_d     = tx_data_q;
        cpu_n_reset_d = cpu_n_reset_q;
        adr_d         = adr_q;
        do_d          = do_q;

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    state_d = StResp;
                    case (rx_data)
                        CmdHalt: begin
                            cpu_n_reset_d = 1'b0;
                            tx_data_d     = ACK_BYTE;
                        end
                        CmdGo: begin
                            cpu_n_reset_d = 1'b1;
                            tx_data_d     = ACK_BYTE;
                        end
                        CmdWrite: begin
                            state_d = StAddr;
                            idx_d   = 2'd0;
                            tcnt_d  = 32'd0;
                        end
                        default: tx_data_d = NAK_BYTE;
                    endcase
                end
            end

            StAddr: begin
                if (rx_valid) begin
                    addr_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d  = idx_q + 2'd1;
                    tcnt_d = 32'd0;
                    if (idx_q == 2'd3) begin
                        state_d = StData;
                    end
                end else if (tcnt_q == TIMEOUT_CYCLES - 1) begin
                    state_d = StIdle;
                    tcnt_d  = 32'd0;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end

            StData: begin
                if (rx_valid) begin
                    data_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d  = idx_q + 2'd1;
                    tcnt_d = 32'd0;
                    if (idx_q == 2'd3) begin
                        // Writes are refused while the CPU runs to avoid racing its fetches.
                        if (cpu_n_reset_q) begin
                            state_d   = StResp;
                            tx_data_d = NAK_BYTE;
                        end else begin
                            state_d = StWrite;
                            wcnt_d  = 32'd0;
                            adr_d   = {addr_q[31:2], 2'b00};
                            do_d    = data_d;
                        end
                    end
                end else if (tcnt_q == TIMEOUT_CYCLES - 1) begin
                    state_d = StIdle;
                    tcnt_d  = 32'd0;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end

            StWrite: begin
                if (wcnt_q == WRITE_CYCLES - 1) begin
                    state_d   = StResp;
                    tx_data_d = ACK_BYTE;
                    wcnt_d    = 32'd0;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end

            StResp: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign dbg_mem_op  = (state_q == StWrite);
    assign dbg_wren    = {4{dbg_mem_op}};
    assign dbg_adr     = adr_q;
    assign dbg_do      = do_q;
    assign tx_valid    = (state_q == StResp);
    assign tx_data     = tx_data_q;
    assign dbg_busy    = (state_q == StWrite) || (state_q == StResp);
    assign cpu_n_reset = cpu_n_reset_q;

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Directed bench for dbg_uart_loader: command table, write-frame table and
// hand-written sequences for backpressure, timeout and reset during a write.
module tb_dbg_uart_loader;

    localparam int unsigned TimeoutCycles = 50;
    localparam int unsigned WriteCycles   = 4;
    localparam logic [7:0]  Ack           = 8'h4B;
    localparam logic [7:0]  Nak           = 8'h45;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        dbg_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dbg_uart_loader #(
        .TIMEOUT_CYCLES(TimeoutCycles),
        .WRITE_CYCLES  (WriteCycles),
        .ACK_BYTE      (Ack),
        .NAK_BYTE      (Nak)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cpu_n_reset(cpu_n_reset),
        .dbg_mem_op (dbg_mem_op),
        .dbg_wren   (dbg_wren),
        .dbg_adr    (dbg_adr),
        .dbg_do     (dbg_do),
        .dbg_busy   (dbg_busy)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] exp_tx;
        logic       exp_cpu;
    } cmd_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_adr;
    } wr_vec_t;

    cmd_vec_t cmd_tbl[5];
    wr_vec_t  wr_tbl[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [31:0] data);
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic exp_write, input logic [31:0] exp_adr);
        int n;
        tx_ready = 1'b1;
        send_frame(addr, data);
        if (exp_write) begin
            check("wr_mem_op", {31'd0, dbg_mem_op}, 32'd1);
            check("wr_wren", {28'd0, dbg_wren}, 32'hF);
            check("wr_adr", dbg_adr, exp_adr);
            check("wr_do", dbg_do, data);
            check("wr_busy", {31'd0, dbg_busy}, 32'd1);
            n = 0;
            while (dbg_mem_op === 1'b1 && n < 20) begin
                n++;
                tick();
            end
            check("wr_len", n, WriteCycles);
            check("wr_wren_off", {28'd0, dbg_wren}, 32'd0);
            check("wr_ack_valid", {31'd0, tx_valid}, 32'd1);
            check("wr_ack_data", {24'd0, tx_data}, {24'd0, Ack});
            check("wr_adr_hold", dbg_adr, exp_adr);
        end else begin
            check("nw_mem_op", {31'd0, dbg_mem_op}, 32'd0);
            check("nw_nak_valid", {31'd0, tx_valid}, 32'd1);
            check("nw_nak_data", {24'd0, tx_data}, {24'd0, Nak});
        end
        tick();
        check("resp_drop", {31'd0, tx_valid}, 32'd0);
        check("resp_idle_mem_op", {31'd0, dbg_mem_op}, 32'd0);
    endtask

    initial begin
        logic activity;

        cmd_tbl[0] = '{cmd: 8'h47, exp_tx: Ack, exp_cpu: 1'b1};
        cmd_tbl[1] = '{cmd: 8'h58, exp_tx: Nak, exp_cpu: 1'b1};
        cmd_tbl[2] = '{cmd: 8'h48, exp_tx: Ack, exp_cpu: 1'b0};
        cmd_tbl[3] = '{cmd: 8'hAA, exp_tx: Nak, exp_cpu: 1'b0};
        cmd_tbl[4] = '{cmd: 8'h47, exp_tx: Ack, exp_cpu: 1'b1};

        wr_tbl[0] = '{addr: 32'h0002_0000, data: 32'h0000_006F, exp_adr: 32'h0002_0000};
        wr_tbl[1] = '{addr: 32'h0002_0007, data: 32'h0000_0001, exp_adr: 32'h0002_0004};

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("rst_mem_op", {31'd0, dbg_mem_op}, 32'd0);
        check("rst_wren", {28'd0, dbg_wren}, 32'd0);
        check("rst_adr", dbg_adr, 32'd0);
        check("rst_do", dbg_do, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, dbg_busy}, 32'd0);

        for (int i = 0; i < 2; i++) begin
            do_write(wr_tbl[i].addr, wr_tbl[i].data, 1'b1, wr_tbl[i].exp_adr);
        end

        for (int i = 0; i < 5; i++) begin
            send_byte(cmd_tbl[i].cmd);
            check("cmd_valid", {31'd0, tx_valid}, 32'd1);
            check("cmd_data", {24'd0, tx_data}, {24'd0, cmd_tbl[i].exp_tx});
            check("cmd_cpu", {31'd0, cpu_n_reset}, {31'd0, cmd_tbl[i].exp_cpu});
            check("cmd_busy", {31'd0, dbg_busy}, 32'd1);
            tick();
            check("cmd_drop", {31'd0, tx_valid}, 32'd0);
        end

        // CPU running: write must be refused; previous write values stay on the port.
        do_write(32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("nw_adr_hold", dbg_adr, 32'h0002_0004);
        send_byte(8'h48);
        check("halt_cpu", {31'd0, cpu_n_reset}, 32'd0);
        check("halt_ack", {24'd0, tx_data}, {24'd0, Ack});
        tick();

        tx_ready = 1'b0;
        send_byte(8'hAA);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) send_byte(8'h47);
            else tick();
            check("bp_valid", {31'd0, tx_valid}, 32'd1);
            check("bp_data", {24'd0, tx_data}, {24'd0, Nak});
        end
        check("bp_cpu_unchanged", {31'd0, cpu_n_reset}, 32'd0);
        tx_ready = 1'b1;
        tick();
        check("bp_drop", {31'd0, tx_valid}, 32'd0);

        send_byte(8'h57);
        for (int i = 0; i < 3; i++) send_byte(8'h11);
        activity = 1'b0;
        for (int i = 0; i < TimeoutCycles + 10; i++) begin
            tick();
            activity = activity | tx_valid | dbg_mem_op;
        end
        check("to_quiet", {31'd0, activity}, 32'd0);
        check("to_cpu", {31'd0, cpu_n_reset}, 32'd0);
        do_write(32'h0000_0103, 32'h8765_4321, 1'b1, 32'h0000_0100);

        send_frame(32'h0000_0200, 32'h0000_5555);
        tick();
        check("rw_mem_op_2nd", {31'd0, dbg_mem_op}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_mem_op", {31'd0, dbg_mem_op}, 32'd0);
        check("rw_wren", {28'd0, dbg_wren}, 32'd0);
        check("rw_cpu", {31'd0, cpu_n_reset}, 32'd0);
        check("rw_adr", dbg_adr, 32'd0);
        activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            activity = activity | tx_valid | dbg_mem_op;
        end
        check("rw_no_resp", {31'd0, activity}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
